// File: rtl/ir_nec_pkg.sv
// Shared types, segment lengths and helpers for the NEC IR transmitter.
// Optional repeat-code support is enabled with macro IR_NEC_REPEAT_EN.
package ir_nec_pkg;

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LEAD_MARK  = 3'd1,
        S_LEAD_SPACE = 3'd2,
        S_BIT_MARK   = 3'd3,
        S_BIT_SPACE  = 3'd4,
        S_STOP_MARK  = 3'd5
`ifdef IR_NEC_REPEAT_EN
        , S_REP_SPACE = 3'd6
`endif
    } ir_state_e;

    localparam int LEAD_MARK_U  = 16;
    localparam int LEAD_SPACE_U = 8;
    localparam int REP_SPACE_U  = 4;
    localparam int BIT_MARK_U   = 1;
    localparam int ZERO_SPACE_U = 1;
    localparam int ONE_SPACE_U  = 3;
    localparam int STOP_U       = 1;

    // Longest segment is the leader mark; the segment counter only needs 0..15.
    localparam int SEG_W = $clog2(LEAD_MARK_U);

    function automatic logic is_mark(input ir_state_e s);
        return (s == S_LEAD_MARK) || (s == S_BIT_MARK) || (s == S_STOP_MARK);
    endfunction

    function automatic logic [SEG_W-1:0] seg_last(input ir_state_e s, input logic cur_bit);
        logic [SEG_W-1:0] r;
        case (s)
            S_LEAD_MARK:  r = SEG_W'(LEAD_MARK_U - 1);
            S_LEAD_SPACE: r = SEG_W'(LEAD_SPACE_U - 1);
            S_BIT_MARK:   r = SEG_W'(BIT_MARK_U - 1);
            S_BIT_SPACE:  r = cur_bit ? SEG_W'(ONE_SPACE_U - 1) : SEG_W'(ZERO_SPACE_U - 1);
            S_STOP_MARK:  r = SEG_W'(STOP_U - 1);
`ifdef IR_NEC_REPEAT_EN
            S_REP_SPACE:  r = SEG_W'(REP_SPACE_U - 1);
`endif
            default:      r = SEG_W'(0);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier oscillator: toggles every CARRIER_HALF cycles while enabled,
// restarts high on phase_rst and is held low when disabled.
module ir_carrier_gen #(
    parameter int CARRIER_HALF = 658
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic phase_rst,
    output logic carrier
);
    localparam int CW = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          carrier_q, carrier_d;

    // Next carrier phase and half-period count.
    always_comb begin
        cnt_d     = cnt_q;
        carrier_d = carrier_q;
        if (!en) begin
            cnt_d     = CW'(0);
            carrier_d = 1'b0;
        end else if (phase_rst) begin
            cnt_d     = CW'(0);
            carrier_d = 1'b1;
        end else if (cnt_q == CW'(CARRIER_HALF - 1)) begin
            cnt_d     = CW'(0);
            carrier_d = ~carrier_q;
        end else begin
            cnt_d     = cnt_q + CW'(1);
            carrier_d = carrier_q;
        end
    end

    // Carrier state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= CW'(0);
            carrier_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            carrier_q <= carrier_d;
        end
    end

    assign carrier = carrier_q;

endmodule

// File: rtl/ir_nec_tx.sv
// NEC IR frame encoder: serialises a code word LSB-first as pulse-distance
// bursts on a modulated carrier. Repeat codes are added by IR_NEC_REPEAT_EN.
module ir_nec_tx
    import ir_nec_pkg::*;
#(
    parameter int NBITS        = 32,
    parameter int UNIT_CYC     = 28125,
    parameter int CARRIER_HALF = 658
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             start,
`ifdef IR_NEC_REPEAT_EN
    input  logic             repeat_req,
`endif
    input  logic [NBITS-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             ir_env,
    output logic             ir_out
);
    localparam int UW = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

    ir_state_e        state_q, state_d;
    logic [UW-1:0]    unit_q, unit_d;
    logic [SEG_W-1:0] seg_q, seg_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [NBITS-1:0] shift_q, shift_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             env_q, env_d;
    logic             rep_q, rep_d;
    logic             seg_end_s;
    logic             phase_rst_s;
    logic             carrier_s;

    // Sequencing of frame segments, unit/segment timing and shift register.
    always_comb begin
        state_d     = state_q;
        unit_d      = unit_q;
        seg_d       = seg_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        rep_d       = rep_q;
        done_d      = 1'b0;
        seg_end_s   = (unit_q == UW'(UNIT_CYC - 1)) && (seg_q == seg_last(state_q, shift_q[0]));

        if (state_q == S_IDLE) begin
            unit_d = UW'(0);
            seg_d  = SEG_W'(0);
        end else if (seg_end_s) begin
            unit_d = UW'(0);
            seg_d  = SEG_W'(0);
        end else if (unit_q == UW'(UNIT_CYC - 1)) begin
            unit_d = UW'(0);
            seg_d  = seg_q + SEG_W'(1);
        end else begin
            unit_d = unit_q + UW'(1);
            seg_d  = seg_q;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_LEAD_MARK;
                    shift_d = data;
                    bit_d   = BW'(0);
`ifdef IR_NEC_REPEAT_EN
                    rep_d   = repeat_req;
`else
                    rep_d   = 1'b0;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LEAD_MARK: begin
                if (seg_end_s) begin
`ifdef IR_NEC_REPEAT_EN
                    state_d = rep_q ? S_REP_SPACE : S_LEAD_SPACE;
`else
                    state_d = S_LEAD_SPACE;
`endif
                end else begin
                    state_d = S_LEAD_MARK;
                end
            end
            S_LEAD_SPACE: begin
                if (seg_end_s) begin
                    state_d = S_BIT_MARK;
                end else begin
                    state_d = S_LEAD_SPACE;
                end
            end
            S_BIT_MARK: begin
                if (seg_end_s) begin
                    state_d = S_BIT_SPACE;
                end else begin
                    state_d = S_BIT_MARK;
                end
            end
            // Space width was chosen by shift_q[0]; advance to the next bit afterwards.
            S_BIT_SPACE: begin
                if (seg_end_s) begin
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + BW'(1);
                    state_d = (bit_q == BW'(NBITS - 1)) ? S_STOP_MARK : S_BIT_MARK;
                end else begin
                    state_d = S_BIT_SPACE;
                end
            end
`ifdef IR_NEC_REPEAT_EN
            S_REP_SPACE: begin
                if (seg_end_s) begin
                    state_d = S_STOP_MARK;
                end else begin
                    state_d = S_REP_SPACE;
                end
            end
`endif
            S_STOP_MARK: begin
                if (seg_end_s) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = S_STOP_MARK;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d      = (state_d != S_IDLE);
        env_d       = is_mark(state_d);
        // Every mark is entered from a different state, so a state change marks its first cycle.
        phase_rst_s = env_d && (state_d != state_q);
    end

    // Frame state registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= S_IDLE;
            unit_q  <= UW'(0);
            seg_q   <= SEG_W'(0);
            bit_q   <= BW'(0);
            shift_q <= '0;
            rep_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            env_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unit_q  <= unit_d;
            seg_q   <= seg_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rep_q   <= rep_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            env_q   <= env_d;
        end
    end

    ir_carrier_gen #(
        .CARRIER_HALF (CARRIER_HALF)
    ) u_carrier (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .en        (env_d),
        .phase_rst (phase_rst_s),
        .carrier   (carrier_s)
    );

    assign busy   = busy_q;
    assign done   = done_q;
    assign ir_env = env_q;
    assign ir_out = env_q & carrier_s;

endmodule

// File: tb/tb_ir_nec_tx.sv
// Self-checking bench for ir_nec_tx (UNIT_CYC=4, CARRIER_HALF=1, NBITS=32).
// Expected envelope run lengths are queued per frame and compared as the DUT emits them.
module tb_ir_nec_tx;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data = 32'h0;
    logic        repeat_req = 1'b0;
    logic        busy, done, ir_env, ir_out;

    int n_cmp = 0;
    int n_err = 0;

    int got_q[$];
    int exp_q[$];
    int exp_done;
    int cap_done_at, cap_bad_car, cap_bad_busy;

    always #5 ACLK = ~ACLK;

    ir_nec_tx #(
        .NBITS        (32),
        .UNIT_CYC     (4),
        .CARRIER_HALF (1)
    ) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .start      (start),
`ifdef IR_NEC_REPEAT_EN
        .repeat_req (repeat_req),
`endif
        .data       (data),
        .busy       (busy),
        .done       (done),
        .ir_env     (ir_env),
        .ir_out     (ir_out)
    );

    // Expected envelope runs (mark first) and done latency for one frame.
    task automatic build_expected(input logic [31:0] d, input bit rep);
        exp_q.delete();
        exp_q.push_back(64);
        if (rep) begin
            exp_q.push_back(16);
        end else begin
            exp_q.push_back(32);
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back(4);
                exp_q.push_back(d[i] ? 12 : 4);
            end
        end
        exp_q.push_back(4);
        exp_done = 1;
        foreach (exp_q[i]) exp_done += exp_q[i];
    endtask

    // Records envelope runs until done (bounded); optionally pulses start mid-frame.
    task automatic capture(input int inject_at);
        int   cnt;
        int   run;
        logic lvl;
        got_q.delete();
        cap_done_at  = -1;
        cap_bad_car  = 0;
        cap_bad_busy = 0;
        cnt = 0;
        run = 0;
        lvl = 1'b1;
        while (cnt < 1000 && cap_done_at < 0) begin
            @(posedge ACLK);
            #1;
            start = 1'b0;
            cnt++;
            if (cnt == inject_at) begin
                start = 1'b1;
                data  = ~data;
            end
            if (done === 1'b1) begin
                cap_done_at = cnt;
                got_q.push_back(run);
                if (busy !== 1'b0) cap_bad_busy++;
            end else begin
                if (busy !== 1'b1) cap_bad_busy++;
                if (run > 0 && ir_env !== lvl) begin
                    got_q.push_back(run);
                    run = 0;
                end
                lvl = ir_env;
                if (ir_out !== ((ir_env === 1'b1) && (run % 2 == 0))) cap_bad_car++;
                run++;
            end
        end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0;
        #12;
        n_cmp += 4;
        if (busy !== 1'b0)   begin n_err++; $display("FAIL reset_busy got %b exp 0", busy); end
        if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done got %b exp 0", done); end
        if (ir_env !== 1'b0) begin n_err++; $display("FAIL reset_env got %b exp 0", ir_env); end
        if (ir_out !== 1'b0) begin n_err++; $display("FAIL reset_out got %b exp 0", ir_out); end
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
    endtask

    task automatic test_data_frames();
        logic [31:0] pats [4];
        int          spec_done [4];
        logic [31:0] word;
        int          e, g;
        pats      = '{32'h0000_0000, 32'hFFFF_FFFF, 32'h00FF_10EF, $urandom()};
        spec_done = '{357, 613, 485, 0};
        for (int k = 0; k < 4; k++) begin
            build_expected(pats[k], 1'b0);
            @(negedge ACLK);
            data  = pats[k];
            start = 1'b1;
            capture(0);
            word = 32'h0;
            for (int i = 0; i < 32; i++) begin
                if (3 + 2 * i < got_q.size()) word[i] = (got_q[3 + 2 * i] > 8);
            end
            n_cmp++;
            if (word !== pats[k]) begin n_err++; $display("FAIL decode_%0d got %h exp %h", k, word, pats[k]); end
            n_cmp++;
            if (got_q.size() != exp_q.size()) begin
                n_err++; $display("FAIL runs_count_%0d got %0d exp %0d", k, got_q.size(), exp_q.size());
            end
            for (int i = 0; exp_q.size() > 0; i++) begin
                e = exp_q.pop_front();
                g = (i < got_q.size()) ? got_q[i] : -1;
                n_cmp++;
                if (g !== e) begin n_err++; $display("FAIL run_%0d_%0d got %0d exp %0d", k, i, g, e); end
            end
            n_cmp += 3;
            if (cap_done_at != exp_done) begin n_err++; $display("FAIL done_lat_%0d got %0d exp %0d", k, cap_done_at, exp_done); end
            if (cap_bad_car != 0) begin n_err++; $display("FAIL carrier_%0d got %0d bad exp 0", k, cap_bad_car); end
            if (cap_bad_busy != 0) begin n_err++; $display("FAIL busy_%0d got %0d bad exp 0", k, cap_bad_busy); end
            if (spec_done[k] != 0) begin
                n_cmp++;
                if (cap_done_at != spec_done[k]) begin
                    n_err++; $display("FAIL spec_done_%0d got %0d exp %0d", k, cap_done_at, spec_done[k]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int e, g, n_done, n_busy;
        logic [31:0] a, b;
        a = 32'hA5C3_0F96;
        b = 32'h1234_5678;
        build_expected(a, 1'b0);
        @(negedge ACLK);
        data  = a;
        start = 1'b1;
        capture(100);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (i < got_q.size()) ? got_q[i] : -1;
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL ignore_run_%0d got %0d exp %0d", i, g, e); end
        end
        n_cmp++;
        if (cap_done_at != exp_done) begin n_err++; $display("FAIL ignore_done got %0d exp %0d", cap_done_at, exp_done); end
        // Still inside the done cycle: this start must be taken immediately.
        build_expected(b, 1'b0);
        data  = b;
        start = 1'b1;
        capture(0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (i < got_q.size()) ? got_q[i] : -1;
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL b2b_run_%0d got %0d exp %0d", i, g, e); end
        end
        n_cmp++;
        if (cap_done_at != exp_done) begin n_err++; $display("FAIL b2b_done got %0d exp %0d", cap_done_at, exp_done); end
        n_done = 0;
        n_busy = 0;
        repeat (20) begin
            @(posedge ACLK);
            #1;
            if (done === 1'b1) n_done++;
            if (busy === 1'b1) n_busy++;
        end
        n_cmp += 2;
        if (n_done != 0) begin n_err++; $display("FAIL extra_done got %0d exp 0", n_done); end
        if (n_busy != 0) begin n_err++; $display("FAIL extra_busy got %0d exp 0", n_busy); end
    endtask

    task automatic test_abort();
        int e, g, n_done;
        logic [31:0] d;
        @(negedge ACLK);
        data  = 32'h0000_0000;
        start = 1'b1;
        repeat (98) begin
            @(posedge ACLK);
            #1;
            start = 1'b0;
        end
        n_cmp++;
        if (ir_env !== 1'b1) begin n_err++; $display("FAIL abort_in_mark got %b exp 1", ir_env); end
        #2;
        ARESETN = 1'b0;
        #1;
        n_cmp += 3;
        if (ir_out !== 1'b0) begin n_err++; $display("FAIL abort_out got %b exp 0", ir_out); end
        if (ir_env !== 1'b0) begin n_err++; $display("FAIL abort_env got %b exp 0", ir_env); end
        if (busy !== 1'b0)   begin n_err++; $display("FAIL abort_busy got %b exp 0", busy); end
        n_done = 0;
        repeat (3) begin
            @(posedge ACLK);
            #1;
            if (done === 1'b1) n_done++;
        end
        @(negedge ACLK);
        ARESETN = 1'b1;
        repeat (10) begin
            @(posedge ACLK);
            #1;
            if (done === 1'b1 || busy === 1'b1) n_done++;
        end
        n_cmp++;
        if (n_done != 0) begin n_err++; $display("FAIL abort_no_done got %0d exp 0", n_done); end
        d = $urandom();
        build_expected(d, 1'b0);
        @(negedge ACLK);
        data  = d;
        start = 1'b1;
        capture(0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (i < got_q.size()) ? got_q[i] : -1;
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL post_abort_run_%0d got %0d exp %0d", i, g, e); end
        end
        n_cmp += 2;
        if (cap_done_at != exp_done) begin n_err++; $display("FAIL post_abort_done got %0d exp %0d", cap_done_at, exp_done); end
        if (cap_bad_car != 0) begin n_err++; $display("FAIL post_abort_carrier got %0d bad exp 0", cap_bad_car); end
    endtask

`ifdef IR_NEC_REPEAT_EN
    task automatic test_repeat();
        int e, g;
        build_expected(32'h0, 1'b1);
        @(negedge ACLK);
        data       = 32'hDEAD_BEEF;
        repeat_req = 1'b1;
        start      = 1'b1;
        capture(0);
        repeat_req = 1'b0;
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front();
            g = (i < got_q.size()) ? got_q[i] : -1;
            n_cmp++;
            if (g !== e) begin n_err++; $display("FAIL repeat_run_%0d got %0d exp %0d", i, g, e); end
        end
        n_cmp += 2;
        if (got_q.size() != 3) begin n_err++; $display("FAIL repeat_runs got %0d exp 3", got_q.size()); end
        if (cap_done_at != 85) begin n_err++; $display("FAIL repeat_done got %0d exp 85", cap_done_at); end
    endtask
`endif

    initial begin
        test_reset();
        test_data_frames();
        test_back_to_back();
        test_abort();
`ifdef IR_NEC_REPEAT_EN
        test_repeat();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
